// File: rtl/ldpc_fmt_pkg.sv
// Shared format constants for the LDPC message-path converters.
package ldpc_fmt_pkg;

    localparam logic MODE_T2S = 1'b0;
    localparam logic MODE_S2T = 1'b1;

    localparam int unsigned MAX_W = 32;

    // Code with only the top bit of a w-bit word set: most-negative TC value, negative-zero SM value
    function automatic logic [MAX_W-1:0] min_code(input int unsigned w);
        min_code = MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/fmt_conv_lane.sv
// Combinational single-word converter between two's complement and sign-magnitude.
module fmt_conv_lane
    import ldpc_fmt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 6
) (
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] word,
    output logic [DATA_WIDTH-1:0] word_c,
    output logic                  sat_c
);

    localparam int unsigned MAG_W = DATA_WIDTH - 1;
    localparam logic [DATA_WIDTH-1:0] MIN_CODE = DATA_WIDTH'(min_code(DATA_WIDTH));

    logic [DATA_WIDTH-1:0] neg_c;

    // Convert one word; the single unrepresentable input in each direction raises sat
    always_comb begin
        word_c = word;
        sat_c  = 1'b0;
        neg_c  = DATA_WIDTH'(0) - word;
        if (mode == MODE_T2S) begin
            if (word == MIN_CODE) begin
                word_c = '1;
                sat_c  = 1'b1;
            end else if (word[DATA_WIDTH-1]) begin
                word_c = {1'b1, neg_c[MAG_W-1:0]};
            end
        end else begin
            if (word[DATA_WIDTH-1]) begin
                if (word[MAG_W-1:0] == '0) begin
                    word_c = '0;
                    sat_c  = 1'b1;
                end else begin
                    word_c = DATA_WIDTH'(0) - {1'b0, word[MAG_W-1:0]};
                end
            end
        end
    end

endmodule

// File: rtl/tc_sm_conv_pipe.sv
// Two-stage elastic multi-lane TC<->SM converter with saturation-event counter.
module tc_sm_conv_pipe
    import ldpc_fmt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned N_LANES    = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_mode,
    input  logic [N_LANES*DATA_WIDTH-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_LANES*DATA_WIDTH-1:0] out_data,
    output logic [N_LANES-1:0]            out_sat,
    input  logic                          sat_clr,
    output logic [CNT_WIDTH-1:0]          sat_cnt
);

    localparam int unsigned BUS_W = N_LANES * DATA_WIDTH;
    localparam int unsigned POP_W = $clog2(N_LANES + 1);
    localparam int unsigned SUM_W = CNT_WIDTH + POP_W;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic             s1_valid;
    logic             s1_mode;
    logic [BUS_W-1:0] s1_data;
    logic             s1_adv_c;
    logic             out_hs_c;
    logic [BUS_W-1:0] conv_data_c;
    logic [N_LANES-1:0] conv_sat_c;
    logic [POP_W-1:0] pop_c;
    logic [SUM_W-1:0] sum_c;
    logic [CNT_WIDTH-1:0] cnt_nxt_c;

    assign s1_adv_c = !out_valid || out_ready;
    assign in_ready = !s1_valid || s1_adv_c;
    assign out_hs_c = out_valid && out_ready;

    // Stage 1: capture the raw beat together with its mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_T2S;
            s1_data  <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= in_mode;
                s1_data <= in_data;
            end
        end
    end

    // Per-lane converters between the two stages
    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        fmt_conv_lane #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_lane (
            .mode  (s1_mode),
            .word  (s1_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .word_c(conv_data_c[k*DATA_WIDTH +: DATA_WIDTH]),
            .sat_c (conv_sat_c[k])
        );
    end

    // Stage 2: hold converted data and flags, frozen while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else if (s1_adv_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= conv_data_c;
                out_sat  <= conv_sat_c;
            end
        end
    end

    // Next counter value: clear first, then add delivered saturations, clamped at max
    always_comb begin
        pop_c     = '0;
        sum_c     = '0;
        cnt_nxt_c = sat_cnt;
        for (int k = 0; k < N_LANES; k++) begin
            pop_c = pop_c + POP_W'(out_sat[k]);
        end
        sum_c = (sat_clr ? SUM_W'(0) : SUM_W'(sat_cnt)) + SUM_W'(pop_c);
        if (out_hs_c) begin
            cnt_nxt_c = (sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_WIDTH'(sum_c);
        end else if (sat_clr) begin
            cnt_nxt_c = '0;
        end
    end

    // Saturation-event counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else begin
            sat_cnt <= cnt_nxt_c;
        end
    end

endmodule

// File: tb/tb_tc_sm_conv_pipe.sv
// Randomized scoreboard bench for tc_sm_conv_pipe (16-bit and 2-bit counter instances).
module tb_tc_sm_conv_pipe;

    localparam int unsigned DW    = 6;
    localparam int unsigned NL    = 4;
    localparam int unsigned BUS_W = DW * NL;
    localparam int HALF = 1 << (DW - 1);
    localparam int FULL = 1 << DW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_mode = 1'b0;
    logic [BUS_W-1:0] in_data = '0;
    logic             out_ready = 1'b0;
    logic             sat_clr = 1'b0;

    logic             in_ready, out_valid;
    logic [BUS_W-1:0] out_data;
    logic [NL-1:0]    out_sat;
    logic [15:0]      sat_cnt;
    logic             in_ready2, out_valid2;
    logic [BUS_W-1:0] out_data2;
    logic [NL-1:0]    out_sat2;
    logic [1:0]       sat_cnt2;

    tc_sm_conv_pipe #(.DATA_WIDTH(DW), .N_LANES(NL), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .sat_clr(sat_clr), .sat_cnt(sat_cnt)
    );

    tc_sm_conv_pipe #(.DATA_WIDTH(DW), .N_LANES(NL), .CNT_WIDTH(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .out_sat(out_sat2),
        .sat_clr(sat_clr), .sat_cnt(sat_cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BUS_W-1:0] d;
        logic [NL-1:0]    s;
        int               acc;
        bit               stalled;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int m_cnt = 0;
    int m_cnt2 = 0;
    bit p_stall = 0;
    logic [BUS_W-1:0] p_data;
    logic [NL-1:0]    p_sat;
    bit last_in_ready;
    bit obs_valid;
    logic [BUS_W-1:0] obs_data;
    logic [NL-1:0]    obs_sat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference conversion of one word from the format rules, in integer arithmetic
    function automatic void ref_word(input bit mode, input int x, output int y, output bit s);
        int v, m;
        s = 0;
        if (!mode) begin
            v = (x >= HALF) ? x - FULL : x;
            if (v == -HALF) begin y = FULL - 1; s = 1; end
            else if (v < 0) y = HALF + (-v);
            else y = v;
        end else begin
            m = x % HALF;
            if (x < HALF) y = m;
            else if (m == 0) begin y = 0; s = 1; end
            else y = (FULL - m) % FULL;
        end
    endfunction

    function automatic logic [BUS_W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
        logic [BUS_W-1:0] r;
        r = {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
        return r;
    endfunction

    function automatic int clamp(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // One clock cycle: check held state, drive inputs, score the handshakes about to happen
    task automatic step(input bit iv, input bit md, input logic [BUS_W-1:0] d,
                        input bit ordy, input bit clr);
        exp_t e;
        int y, pop, base;
        bit s;
        @(negedge clk);
        cyc++;
        check("sat_cnt", 64'(sat_cnt), 64'(m_cnt));
        check("sat_cnt_c2", 64'(sat_cnt2), 64'(m_cnt2));
        if (p_stall) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'(out_data), 64'(p_data));
            check("hold_sat", 64'(out_sat), 64'(p_sat));
        end
        in_valid = iv; in_mode = md; in_data = d; out_ready = ordy; sat_clr = clr;
        #1;
        last_in_ready = in_ready;
        obs_valid = out_valid; obs_data = out_data; obs_sat = out_sat;
        if (out_valid && !out_ready)
            foreach (q[i]) q[i].stalled = 1;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                check("out_data", 64'(out_data), 64'(e.d));
                check("out_sat", 64'(out_sat), 64'(e.s));
                if (!e.stalled) check("latency", 64'(cyc - e.acc), 64'd2);
                pop = $countones(e.s);
                base = clr ? 0 : m_cnt;
                m_cnt = clamp(base + pop, 65535);
                base = clr ? 0 : m_cnt2;
                m_cnt2 = clamp(base + pop, 3);
            end
        end else if (clr) begin
            m_cnt = 0;
            m_cnt2 = 0;
        end
        p_stall = out_valid && !out_ready;
        p_data = out_data;
        p_sat = out_sat;
        if (iv && in_ready) begin
            e.d = '0; e.s = '0; e.acc = cyc; e.stalled = 0;
            for (int k = 0; k < NL; k++) begin
                ref_word(md, int'(d[k*DW +: DW]), y, s);
                e.d[k*DW +: DW] = DW'(y);
                e.s[k] = s;
            end
            q.push_back(e);
            check("in_flight", 64'(q.size() <= 2), 64'd1);
        end
    endtask

    // Asynchronous reset mid-cycle; pipeline and counters must clear at once
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0; in_valid = 0; out_ready = 0; sat_clr = 0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_sat", 64'(out_sat), 64'd0);
        check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
        check("rst_sat_cnt_c2", 64'(sat_cnt2), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        m_cnt = 0; m_cnt2 = 0; p_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [BUS_W-1:0] rand_beat();
        logic [BUS_W-1:0] r;
        for (int k = 0; k < NL; k++)
            r[k*DW +: DW] = ($urandom_range(3) == 0) ? DW'(HALF) : DW'($urandom);
        return r;
    endfunction

    initial begin
        do_reset();

        // Directed T2S beat
        step(1, 1'b0, pack4('h3B, 'h05, 'h20, 'h00), 1, 0);
        step(0, 1'b0, '0, 1, 0);
        step(0, 1'b0, '0, 1, 0);
        check("t1_valid", 64'(obs_valid), 64'd1);
        check("t1_data", 64'(obs_data), 64'(pack4('h25, 'h05, 'h3F, 'h00)));
        check("t1_sat", 64'(obs_sat), 64'b0100);
        step(0, 1'b0, '0, 1, 0);
        check("t1_cnt", 64'(sat_cnt), 64'd1);

        // Directed S2T beat
        step(1, 1'b1, pack4('h25, 'h1F, 'h20, 'h3F), 1, 0);
        step(0, 1'b0, '0, 1, 0);
        step(0, 1'b0, '0, 1, 0);
        check("t2_data", 64'(obs_data), 64'(pack4('h3B, 'h1F, 'h00, 'h21)));
        check("t2_sat", 64'(obs_sat), 64'b0100);

        // Back-to-back beats alternating mode
        for (int i = 0; i < 10; i++) step(1, 1'(i % 2), rand_beat(), 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1'b0, '0, 1, 0);

        // Downstream stall with continuous input
        for (int i = 0; i < 5; i++) begin
            step(1, 1'($urandom_range(1)), rand_beat(), 0, 0);
            check("t4_in_ready", 64'(last_in_ready), 64'(i < 2));
        end
        for (int i = 0; i < 4; i++) step(0, 1'b0, '0, 1, 0);

        // Sticky 2-bit counter, then clear coinciding with a 4-saturation delivery
        step(0, 1'b0, '0, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 1'b0, pack4('h20, 'h20, 'h20, 'h20), 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1'b0, '0, 1, 0);
        check("t5_sticky", 64'(sat_cnt2), 64'd3);
        step(1, 1'b0, pack4('h20, 'h20, 'h20, 'h20), 1, 0);
        step(0, 1'b0, '0, 1, 0);
        step(0, 1'b0, '0, 1, 1);
        @(posedge clk);
        #1;
        check("t5_clr_add", 64'(sat_cnt), 64'd4);
        check("t5_clr_add_c2", 64'(sat_cnt2), 64'd3);

        // Reset with two beats in flight, then a fresh beat
        step(1, 1'b0, rand_beat(), 0, 0);
        step(1, 1'b1, rand_beat(), 0, 0);
        do_reset();
        step(1, 1'b1, pack4('h25, 'h1F, 'h20, 'h3F), 1, 0);
        step(0, 1'b0, '0, 1, 0);
        step(0, 1'b0, '0, 1, 0);
        check("t6_valid", 64'(obs_valid), 64'd1);
        check("t6_data", 64'(obs_data), 64'(pack4('h3B, 'h1F, 'h00, 'h21)));

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(9) < 7), 1'($urandom_range(1)), rand_beat(),
                 1'($urandom_range(9) < 7), 1'($urandom_range(19) == 0));
        for (int i = 0; i < 6; i++) step(0, 1'b0, '0, 1, 0);
        check("drained", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
